// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program-counter sequencer with branch, memory-wait timeout, halt and fault handling
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  format,
  input  logic [3:0]  opcode,
  input  logic [15:0] jmp_loc,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic [15:0] pc,
  output logic        reg_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic        halted,
  output logic        fault,
  output logic [15:0] instr_count
);
  typedef enum logic [2:0] {IDLE, RUN, MEM_WAIT, HALTED, FAULT} state_t;
  localparam logic [3:0] TMO_LAST = 4'(MEM_TIMEOUT - 1);
  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d, cnt_q, cnt_d;
  logic        req_q, req_d, mwe_q, mwe_d, we_c;
  logic [3:0]  op_q, op_d, tmo_q, tmo_d;
  logic [15:0] pc_inc, cnt_inc;
  logic        unused_fmt;
  assign unused_fmt = ^format;
  assign pc_inc  = pc_q + 16'd1;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    mwe_d   = mwe_q;
    op_d    = op_q;
    tmo_d   = tmo_q;
    we_c    = 1'b0;
    case (state_q)
      RUN: begin
        cnt_d = cnt_inc;
        case (opcode)
          4'hE: state_d = HALTED;
          4'h2: pc_d = jmp_loc;
          4'hA, 4'hB, 4'hC: pc_d = branch_taken ? jmp_loc : pc_inc;
          4'h0, 4'h1, 4'h3: begin
            cnt_d   = cnt_q;
            state_d = MEM_WAIT;
            op_d    = opcode;
            req_d   = 1'b1;
            mwe_d   = (opcode == 4'h3);
            tmo_d   = 4'd0;
          end
          4'hF: pc_d = pc_inc;
          default: begin
            we_c = 1'b1;
            pc_d = pc_inc;
          end
        endcase
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
          pc_d    = pc_inc;
          cnt_d   = cnt_inc;
          req_d   = 1'b0;
          mwe_d   = 1'b0;
          we_c    = (op_q != 4'h3);
        end else if (tmo_q == TMO_LAST) begin
          state_d = FAULT;
          req_d   = 1'b0;
          mwe_d   = 1'b0;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end
      IDLE, HALTED, FAULT: begin
        state_d = start ? RUN : state_q;
        pc_d    = start ? RESET_PC : pc_q;
        cnt_d   = start ? 16'd0 : cnt_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= 16'd0;
      req_q   <= 1'b0;
      mwe_q   <= 1'b0;
      op_q    <= 4'd0;
      tmo_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      mwe_q   <= mwe_d;
      op_q    <= op_d;
      tmo_q   <= tmo_d;
    end
  end
  assign reg_we      = rst_n & we_c;
  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign mem_req     = req_q;
  assign mem_we      = mwe_q;
  assign halted      = (state_q == HALTED);
  assign fault       = (state_q == FAULT);
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset and on start.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum MEM_WAIT cycles before fault, range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  start/restart pulse.
REQ-006 format  input  2  decoded instruction format from the instruction ROM.
REQ-007 opcode  input  4  decoded opcode from the instruction ROM.
REQ-008 jmp_loc  input  16  jump/branch target from the instruction ROM.
REQ-009 branch_taken  input  1  compare result for BNE/BEQ/BLT; valid in the RUN cycle.
REQ-010 mem_ready  input  1  data-memory completion handshake.
REQ-011 pc  output  16  registered program counter driving the instruction ROM.
REQ-012 reg_we  output  1  register-file write enable, combinational.
REQ-013 mem_req  output  1  data-memory request, registered.
REQ-014 mem_we  output  1  data-memory write qualifier, registered.
REQ-015 halted  output  1  high in HALTED state.
REQ-016 fault  output  1  high in FAULT state.
REQ-017 instr_count  output  16  retired-instruction counter.

Function
REQ-018 FSM states SHALL be IDLE, RUN, MEM_WAIT, HALTED, FAULT.
REQ-019 In IDLE, HALTED and FAULT, start=1 SHALL load pc=RESET_PC, clear instr_count and enter RUN next cycle.
REQ-020 In RUN and MEM_WAIT, start SHALL be ignored.
REQ-021 In RUN, each cycle SHALL execute the instruction currently decoded at pc.
REQ-022 RUN, opcode 4'hE (HALT): enter HALTED; pc unchanged; instr_count +1.
REQ-023 RUN, opcode 4'h2 (JMP): pc <= jmp_loc; instr_count +1; reg_we=0.
REQ-024 RUN, opcodes 4'hA/4'hB/4'hC (BNE/BEQ/BLT): pc <= jmp_loc when branch_taken=1, else pc+1; instr_count +1; reg_we=0.
REQ-025 RUN, opcodes 4'h0/4'h1/4'h3 (LB/LHB/STR): latch opcode; enter MEM_WAIT; pc held; mem_req=1 from the next cycle; mem_we=1 only for STR; reg_we=0 in the RUN cycle.
REQ-026 RUN, opcodes 4'h4–4'h9 and 4'hD: reg_we=1 for that cycle, pc+1, instr_count +1.
REQ-027 RUN, opcode 4'hF (TBA): execute as NOP; reg_we=0, pc+1, instr_count +1.
REQ-028 In MEM_WAIT, mem_req and mem_we SHALL stay constant until exit.
REQ-029 MEM_WAIT with mem_ready=1 SHALL do all of the following:
- return to RUN, pc+1, instr_count +1;
- deassert mem_req/mem_we the next cycle;
- reg_we=1 in the same cycle for latched LB/LHB only.
REQ-030 MEM_WAIT SHALL count cycles with mem_ready=0 and enter FAULT when the count reaches MEM_TIMEOUT.
REQ-031 mem_ready=1 on the cycle the count reaches MEM_TIMEOUT SHALL complete normally, with no fault.
REQ-032 The timeout counter SHALL clear on every MEM_WAIT entry.
REQ-033 pc+1 SHALL be 16-bit modulo: 16'hFFFF wraps to 16'h0000.
REQ-034 instr_count SHALL saturate at 16'hFFFF.
REQ-035 reg_we SHALL be 0 in IDLE, HALTED and FAULT.
REQ-036 In IDLE, HALTED and FAULT: pc, instr_count and mem_req/mem_we frozen (mem_req=0, mem_we=0).
REQ-037 A format/opcode mismatch SHALL be ignored; dispatch uses opcode only.

Reset
REQ-038 rst_n=0 at a clock edge SHALL force state IDLE, pc=RESET_PC and instr_count=0.
REQ-039 rst_n=0 at a clock edge SHALL force mem_req=0, mem_we=0, halted=0, fault=0 and the timeout counter to 0.
REQ-040 Reset SHALL take priority over start and mem_ready.
REQ-041 Reset mid-MEM_WAIT SHALL drop mem_req the next cycle without retiring the instruction.

Verification
REQ-042 Reset, start, then ROM sequence LIM, ADD, HALT -> pc goes 0,1,2 and holds 2; reg_we high 2 cycles; halted=1; instr_count=3.
REQ-043 JMP at pc=5 with jmp_loc=10 -> pc=10 next cycle. BEQ at pc=10 with branch_taken=0 -> pc=11. BEQ with branch_taken=1, jmp_loc=3 -> pc=3.
REQ-044 LB at pc=4, mem_ready asserted on the 3rd MEM_WAIT cycle:
- mem_req high exactly 3 cycles, mem_we=0;
- reg_we=1 on the ready cycle;
- pc=5 after the ready cycle.
STR variant: mem_we=1 and reg_we=0.
REQ-045 STR with mem_ready held 0 and MEM_TIMEOUT=15 -> FAULT after 15 MEM_WAIT cycles, fault=1, pc unchanged; start then gives pc=0, fault=0, state RUN.
REQ-046 Wrap and saturation:
- pc preset 16'hFFFF via jmp_loc, then NOP -> pc=16'h0000;
- instr_count forced to 16'hFFFF, then a retire -> stays 16'hFFFF.
REQ-047 rst_n=0 during MEM_WAIT -> next cycle mem_req=0, pc=0, instr_count=0, state IDLE; start during RUN has no effect.
